// File: rtl/fifo_serial_tx_pkg.sv
// Shared types and helpers for the FIFO-draining serial transmitter and its baud timer.
// Holds the frame state encoding and the counter-width helper used by both.
package fifo_serial_tx_pkg;

  // 3 bits so PARITY can sit between DATA and STOP when it is built in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_serial_tx_baud.sv
// Bit-time divider: counts 0..DIVISOR-1 and flags the terminal cycle with tick_o.
// Zero latency from count to tick; clr_i holds the count at zero so the next bit starts aligned.
module fifo_serial_tx_baud
  import fifo_serial_tx_pkg::*;
#(
  parameter int DIVISOR = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = cnt_width(DIVISOR);
  localparam logic [CW-1:0] TC = CW'(DIVISOR - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops FIFO words and shifts them out LSB-first as start/data/[parity]/stop frames; tx falls one cycle after the pop.
// Pops only when en and q_ready===1; define FIFO_SERIAL_TX_PARITY_EN to add an even-parity bit.
module fifo_serial_tx
  import fifo_serial_tx_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DIVISOR = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] q,
  input  logic             q_ready,
  output logic             q_out_strobe,
  output logic             tx,
  output logic             busy
);

  localparam int BCW = cnt_width(WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]   bit_q, bit_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             strobe_q, strobe_d;
  logic             tick;
  logic             timer_clr;
  logic             start_ok;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  // X/Z on q_ready must never look like a ready FIFO.
  assign start_ok  = en && (q_ready === 1'b1);
  assign timer_clr = (state_q == ST_IDLE) || (state_q == ST_LOAD);

  fifo_serial_tx_baud #(
    .DIVISOR (DIVISOR)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (timer_clr),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_LOAD;
          shreg_d = q;
`ifdef FIFO_SERIAL_TX_PARITY_EN
          par_d   = ^q;
`endif
        end
      end
      ST_LOAD: begin
        state_d = ST_START;
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + BCW'(1);
          end
        end
      end
`ifdef FIFO_SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          // Chain straight into the next pop so back-to-back frames have no idle gap.
          if (start_ok) begin
            state_d = ST_LOAD;
            shreg_d = q;
`ifdef FIFO_SERIAL_TX_PARITY_EN
            par_d   = ^q;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from next state so the pin is driven straight from flops.
    tx_d = 1'b1;
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shreg_d[0];
`ifdef FIFO_SERIAL_TX_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
    busy_d   = (state_d != ST_IDLE);
    strobe_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
    end
  end

`ifdef FIFO_SERIAL_TX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign tx           = tx_q;
  assign busy         = busy_q;
  assign q_out_strobe = strobe_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx: vector table of single frames plus back-to-back, en gating,
// empty/Z q_ready and mid-frame reset sequences, against a small FIFO model.
`timescale 1ns/1ps
module tb_fifo_serial_tx;

  localparam int DIV = 4;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  localparam int BUSY_LEN = 1 + 11 * DIV;
`else
  localparam int BUSY_LEN = 1 + 10 * DIV;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] q;
  wire        q_ready_w;
  logic       q_out_strobe;
  logic       tx;
  logic       busy;

  logic [7:0] mem [16];
  int         wr_ptr;
  int         rd_ptr = 0;
  int         strobe_cnt = 0;
  logic       qr_z;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign q_ready_w = qr_z ? 1'bz : (wr_ptr != rd_ptr);
  assign q = mem[rd_ptr[3:0]];

  always @(posedge clk) begin
    if (q_out_strobe === 1'b1) begin
      rd_ptr     <= rd_ptr + 1;
      strobe_cnt <= strobe_cnt + 1;
    end
  end

  fifo_serial_tx #(
    .WIDTH   (8),
    .DIVISOR (DIV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .q            (q),
    .q_ready      (q_ready_w),
    .q_out_strobe (q_out_strobe),
    .tx           (tx),
    .busy         (busy)
  );

  typedef struct {
    logic [7:0] word;
    logic [7:0] lsb_first;  // data bits in line order, first bit in the MSB
    logic       par;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic push(input logic [7:0] w);
    mem[wr_ptr[3:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic sample_bit(output logic b, output bit st, inout int bcnt, inout int idx,
                            input int drop_at);
    st = 1'b1;
    b  = 1'b0;
    for (int c = 0; c < DIV; c++) begin
      @(negedge clk);
      if (c == 0) b = tx;
      else if (tx !== b) st = 1'b0;
      if (busy === 1'b1) bcnt++;
      if (idx == drop_at) en = 1'b0;
      idx++;
    end
  endtask

  task automatic capture(input int drop_at, output bit found, output int waited,
                         output logic [7:0] bits, output bit start_ok, output bit stop_ok,
                         output bit clean, output logic par, output int bcnt);
    logic b;
    bit   st;
    int   idx;
    found = 1'b0; waited = 0; bits = '0; start_ok = 1'b0; stop_ok = 1'b0;
    clean = 1'b1; par = 1'b0; bcnt = 0; idx = 1;
    for (int w = 0; w < 300; w++) begin
      @(negedge clk);
      if (q_out_strobe === 1'b1) begin
        found = 1'b1;
        break;
      end
      waited++;
    end
    if (!found) return;
    if (busy === 1'b1) bcnt++;
    sample_bit(b, st, bcnt, idx, drop_at);
    start_ok = st && (b === 1'b0);
    for (int i = 0; i < 8; i++) begin
      sample_bit(b, st, bcnt, idx, drop_at);
      bits  = {bits[6:0], b};
      clean = clean && st;
    end
`ifdef FIFO_SERIAL_TX_PARITY_EN
    sample_bit(b, st, bcnt, idx, drop_at);
    par   = b;
    clean = clean && st;
`endif
    sample_bit(b, st, bcnt, idx, drop_at);
    stop_ok = st && (b === 1'b1);
  endtask

  task automatic check_frame(input string nm, input int drop_at, input logic [7:0] exp_bits,
                             input logic exp_par, input bit exp_no_gap);
    bit found, start_ok, stop_ok, clean;
    int waited, bcnt;
    logic [7:0] bits;
    logic par;
    capture(drop_at, found, waited, bits, start_ok, stop_ok, clean, par, bcnt);
    chk({nm, "_found"}, 32'(found), 32'd1);
    if (!found) return;
    chk({nm, "_data"}, 32'(bits), 32'(exp_bits));
    chk({nm, "_frame"}, {29'd0, start_ok, clean, stop_ok}, 32'h7);
    chk({nm, "_busy_len"}, 32'(bcnt), 32'(BUSY_LEN));
`ifdef FIFO_SERIAL_TX_PARITY_EN
    chk({nm, "_parity"}, 32'(par), 32'(exp_par));
`else
    if (par !== 1'b0 && exp_par === 1'bx) $display("unexpected parity capture");
`endif
    if (exp_no_gap) chk({nm, "_gap"}, 32'(waited), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int s0;
    bit tx_low, busy_seen;

    vecs[0] = '{8'hA5, 8'b10100101, 1'b0};
    vecs[1] = '{8'h07, 8'b11100000, 1'b1};
    vecs[2] = '{8'h03, 8'b11000000, 1'b0};
    vecs[3] = '{8'h01, 8'b10000000, 1'b1};
    vecs[4] = '{8'h80, 8'b00000001, 1'b1};
    vecs[5] = '{8'h5A, 8'b01011010, 1'b0};
    vecs[6] = '{8'hC4, 8'b00100011, 1'b1};
    vecs[7] = '{8'hFF, 8'b11111111, 1'b0};

    reset = 1'b1; en = 1'b0; qr_z = 1'b0; wr_ptr = 0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobe", 32'(q_out_strobe), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    en = 1'b1;

    // Single frames from the vector table.
    for (int v = 0; v < 8; v++) begin
      s0 = strobe_cnt;
      push(vecs[v].word);
      check_frame($sformatf("vec%0d", v), -1, vecs[v].lsb_first, vecs[v].par, 1'b1);
      @(negedge clk);
      chk($sformatf("vec%0d_idle_busy", v), 32'(busy), 32'd0);
      chk($sformatf("vec%0d_strobes", v), 32'(strobe_cnt - s0), 32'd1);
    end

    // Back-to-back frames with no idle cycle between them.
    s0 = strobe_cnt;
    push(8'h00); push(8'hFF); push(8'h3C);
    check_frame("b2b0", -1, 8'b00000000, 1'b0, 1'b1);
    check_frame("b2b1", -1, 8'b11111111, 1'b0, 1'b1);
    check_frame("b2b2", -1, 8'b00111100, 1'b0, 1'b1);
    @(negedge clk);
    chk("b2b_strobes", 32'(strobe_cnt - s0), 32'd3);

    // en dropped during frame 2: it completes, then nothing until en returns.
    s0 = strobe_cnt;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    check_frame("gate1", -1, 8'b10001000, 1'b0, 1'b1);
    check_frame("gate2", 10, 8'b01000100, 1'b0, 1'b1);
    repeat (100) @(negedge clk);
    chk("gate_strobes_held", 32'(strobe_cnt - s0), 32'd2);
    chk("gate_idle_busy", 32'(busy), 32'd0);
    en = 1'b1;
    check_frame("gate3", -1, 8'b11001100, 1'b0, 1'b0);
    check_frame("gate4", -1, 8'b00100010, 1'b0, 1'b1);
    @(negedge clk);
    chk("gate_strobes_total", 32'(strobe_cnt - s0), 32'd4);

    // Empty FIFO, then a word hidden behind a floating q_ready.
    s0 = strobe_cnt; tx_low = 1'b0; busy_seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_low = 1'b1;
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
    qr_z = 1'b1;
    push(8'hC4);
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_low = 1'b1;
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
    chk("empty_z_strobes", 32'(strobe_cnt - s0), 32'd0);
    chk("empty_z_tx_low", 32'(tx_low), 32'd0);
    chk("empty_z_busy", 32'(busy_seen), 32'd0);
    qr_z = 1'b0;
    check_frame("after_z", -1, 8'b00100011, 1'b1, 1'b0);

    // Reset in the middle of DATA bit 3 of an A5 frame.
    push(8'hA5);
    begin
      bit found;
      found = 1'b0;
      for (int w = 0; w < 300; w++) begin
        @(negedge clk);
        if (q_out_strobe === 1'b1) begin
          found = 1'b1;
          break;
        end
      end
      chk("mid_found", 32'(found), 32'd1);
    end
    repeat (DIV + 3 * DIV + 2) @(negedge clk);
    chk("mid_pre_busy", 32'(busy), 32'd1);
    chk("mid_pre_tx_bit3", 32'(tx), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_strobe", 32'(q_out_strobe), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    s0 = strobe_cnt; tx_low = 1'b0; busy_seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_low = 1'b1;
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
    chk("post_rst_quiet", {30'd0, tx_low, busy_seen}, 32'd0);
    chk("post_rst_strobes", 32'(strobe_cnt - s0), 32'd0);
    push(8'h5A);
    check_frame("post_rst", -1, 8'b01011010, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
